// File: rtl/skew_feed_controller_pkg.sv
// ============================================================================
// Module   : skew_feed_controller_pkg
// Brief    : Buffer command codes, controller state enum and lane window helper.
// Revision : 1.0
// ============================================================================
`default_nettype none

package skew_feed_controller_pkg;

  localparam logic [1:0] CMD_IDLE = 2'b00;
  localparam logic [1:0] CMD_ENQ  = 2'b01;
  localparam logic [1:0] CMD_DEQ  = 2'b10;
  localparam logic [1:0] CMD_HOLD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_FIN   = 2'd3
  } state_t;

  // Lane 'lane' drains during the k cycles starting at drain step 'lane'.
  function automatic logic in_window(input int t, input int lane, input int k);
    return (t >= lane) && (t < lane + k);
  endfunction

endpackage

`default_nettype wire

// File: rtl/skew_feed_controller.sv
// ============================================================================
// Module   : skew_feed_controller
// Brief    : Sequences load and skewed drain of ARR_SIZE per-row FIFOs.
// Revision : 1.0
// ============================================================================
`default_nettype none

module skew_feed_controller
  import skew_feed_controller_pkg::*;
#(
  parameter int ARR_SIZE    = 4,
  parameter int QUEUE_DEPTH = 2 * ARR_SIZE,
  parameter int KW          = $clog2(QUEUE_DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [KW-1:0]         k_len,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [2*ARR_SIZE-1:0] buf_state,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int CW = KW + 1;
  localparam logic [CW-1:0] c_one  = CW'(1);
  localparam logic [CW-1:0] c_tail = CW'(ARR_SIZE - 1);

  state_t          r_state;
  logic [KW-1:0]   r_klen;
  logic [CW-1:0]   r_cnt;
  logic            r_busy;
  logic            r_done;
  logic            r_err;

  logic            w_start_ok;
  logic [CW-1:0]   w_load_last;
  logic [CW-1:0]   w_drain_last;

  assign w_start_ok   = (k_len != '0) && (int'(k_len) <= QUEUE_DEPTH);
  assign w_load_last  = {1'b0, r_klen} - c_one;
  // Drain spans k_len + ARR_SIZE - 1 steps so the last lane empties completely.
  assign w_drain_last = {1'b0, r_klen} + c_tail - c_one;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_klen  <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            if (w_start_ok) begin
              r_state <= ST_LOAD;
              r_klen  <= k_len;
              r_cnt   <= '0;
              r_busy  <= 1'b1;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        ST_LOAD: begin
          if (in_valid) begin
            if (r_cnt == w_load_last) begin
              r_state <= ST_DRAIN;
              r_cnt   <= '0;
            end else begin
              r_cnt <= r_cnt + c_one;
            end
          end
        end
        ST_DRAIN: begin
          if (r_cnt == w_drain_last) begin
            r_state <= ST_FIN;
            r_cnt   <= '0;
            r_done  <= 1'b1;
          end else begin
            r_cnt <= r_cnt + c_one;
          end
        end
        ST_FIN: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready = (r_state == ST_LOAD);
  assign busy     = r_busy;
  assign done     = r_done;
  assign err      = r_err;

  for (genvar i = 0; i < ARR_SIZE; i++) begin : g_lane
    logic [1:0] w_cmd;

    always_comb begin
      w_cmd = CMD_IDLE;
      case (r_state)
        ST_LOAD:  w_cmd = in_valid ? CMD_ENQ : CMD_HOLD;
        ST_DRAIN: w_cmd = in_window(int'(r_cnt), i, int'(r_klen)) ? CMD_DEQ : CMD_IDLE;
        default:  w_cmd = CMD_IDLE;
      endcase
    end

    assign buf_state[2*i +: 2] = w_cmd;
  end

endmodule

`default_nettype wire

// File: tb/tb_skew_feed_controller.sv
// Scoreboard bench: a per-cycle reference model pushes expected outputs, a
// negedge monitor pops and compares; directed sequences also checked verbatim.
`default_nettype none

module tb_skew_feed_controller;

  localparam int A  = 4;
  localparam int QD = 8;
  localparam int KW = 4;

  typedef logic [2*A+3:0] exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [KW-1:0] k_len = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [2*A-1:0] buf_state;
  logic          busy;
  logic          done;
  logic          err;

  skew_feed_controller #(.ARR_SIZE(A), .QUEUE_DEPTH(QD), .KW(KW)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .k_len    (k_len),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .buf_state(buf_state),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  exp_t          q_exp[$];
  logic [2*A-1:0] q_log[$];
  int n_chk = 0;
  int n_err = 0;

  // Reference model: phase 0 idle, 1 load, 2 drain, 3 fin.
  int m_phase = 0;
  int m_k     = 0;
  int m_cnt   = 0;
  bit m_err   = 1'b0;

  function automatic exp_t model_out(bit v);
    logic [2*A-1:0] b;
    b = '0;
    for (int i = 0; i < A; i++) begin
      if (m_phase == 1) b[2*i +: 2] = v ? 2'b01 : 2'b11;
      else if (m_phase == 2 && m_cnt >= i && m_cnt < i + m_k) b[2*i +: 2] = 2'b10;
    end
    return {b, (m_phase == 1), (m_phase != 0), (m_phase == 3), m_err};
  endfunction

  function automatic void model_edge(bit s, int k, bit v);
    bit nerr;
    nerr = 1'b0;
    case (m_phase)
      0: if (s) begin
           if (k >= 1 && k <= QD) begin m_phase = 1; m_k = k; m_cnt = 0; end
           else nerr = 1'b1;
         end
      1: if (v) begin
           m_cnt++;
           if (m_cnt == m_k) begin m_phase = 2; m_cnt = 0; end
         end
      2: begin
           m_cnt++;
           if (m_cnt == m_k + A - 1) m_phase = 3;
         end
      default: m_phase = 0;
    endcase
    m_err = nerr;
  endfunction

  task automatic step(bit s, int k, bit v);
    q_exp.push_back(model_out(v));
    start    = s;
    k_len    = k[KW-1:0];
    in_valid = v;
    @(posedge clk);
    model_edge(s, k, v);
    #1;
  endtask

  task automatic rst_step();
    q_exp.push_back('0);
    rst = 1'b1;
    @(posedge clk);
    m_phase = 0; m_cnt = 0; m_err = 1'b0;
    #1;
  endtask

  task automatic finish_pass(bit noisy);
    int guard;
    guard = 0;
    while (m_phase != 0 && guard < 200) begin
      step(noisy && ($urandom_range(3) == 0), int'($urandom_range(15)),
           noisy ? ($urandom_range(9) < 7) : 1'b1);
      guard++;
    end
    if (m_phase != 0) begin
      n_chk++; n_err++;
      $display("FAIL pass_timeout: model phase %0d still active after %0d cycles", m_phase, guard);
    end
  endtask

  task automatic check_log(string nm);
    logic [7:0] c_seq [14];
    c_seq = '{8'h00, 8'h55, 8'h55, 8'h55, 8'h55, 8'h02, 8'h0A, 8'h2A,
              8'hAA, 8'hA8, 8'hA0, 8'h80, 8'h00, 8'h00};
    n_chk++;
    if (q_log.size() != 14) begin
      n_err++;
      $display("FAIL %s_len: got %0d samples want 14", nm, q_log.size());
    end else begin
      for (int i = 0; i < 14; i++) begin
        n_chk++;
        if (q_log[i] !== c_seq[i]) begin
          n_err++;
          $display("FAIL %s_seq[%0d]: buf_state got %h want %h", nm, i, q_log[i], c_seq[i]);
        end
      end
    end
  endtask

  initial begin
    forever begin
      exp_t got;
      exp_t e;
      @(negedge clk);
      got = {buf_state, in_ready, busy, done, err};
      q_log.push_back(buf_state);
      if (q_exp.size() > 0) begin
        e = q_exp.pop_front();
        n_chk++;
        if (got !== e) begin
          n_err++;
          $display("FAIL cycle_out at %0t: {buf_state,in_ready,busy,done,err} got %h want %h",
                   $time, got, e);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    @(posedge clk); #1;
    rst_step();
    rst_step();
    rst = 1'b0;

    // k_len=4 with in_valid held high, compared against the literal sequence
    q_log.delete();
    step(1'b1, 4, 1'b1);
    finish_pass(1'b0);
    step(1'b0, 0, 1'b0);
    check_log("k4");

    // k_len=2 with a gap in in_valid
    step(1'b1, 2, 1'b1);
    step(1'b0, 0, 1'b1);
    step(1'b0, 0, 1'b0);
    step(1'b0, 0, 1'b1);
    finish_pass(1'b0);

    // illegal lengths
    step(1'b1, 0, 1'b1);
    step(1'b0, 0, 1'b0);
    step(1'b1, 9, 1'b0);
    step(1'b0, 0, 1'b0);
    step(1'b0, 0, 1'b0);

    // k_len=1
    step(1'b1, 1, 1'b1);
    finish_pass(1'b0);
    step(1'b0, 0, 1'b0);

    // full-depth pass with start held during busy
    step(1'b1, 8, 1'b1);
    for (int g = 0; g < 100 && m_phase != 0; g++) step(1'b1, 4, 1'b1);
    step(1'b0, 0, 1'b0);
    step(1'b0, 0, 1'b0);

    // asynchronous reset in the 3rd drain cycle
    step(1'b1, 4, 1'b1);
    repeat (4) step(1'b0, 0, 1'b1);
    repeat (2) step(1'b0, 0, 1'b1);
    rst = 1'b1;
    q_exp.push_back('0);
    #1;
    n_chk++;
    if ({buf_state, in_ready, busy, done, err} !== '0) begin
      n_err++;
      $display("FAIL async_rst: outputs got %h want 0 before next edge",
               {buf_state, in_ready, busy, done, err});
    end
    @(posedge clk);
    m_phase = 0; m_cnt = 0; m_err = 1'b0;
    #1;
    rst_step();
    rst = 1'b0;

    q_log.delete();
    step(1'b1, 4, 1'b1);
    finish_pass(1'b0);
    step(1'b0, 0, 1'b0);
    check_log("k4_after_rst");

    // randomized passes with noise on start and in_valid
    repeat (40) begin
      repeat ($urandom_range(2)) step($urandom_range(1) == 1, 0, $urandom_range(1) == 1);
      step(1'b1, int'($urandom_range(15)), $urandom_range(9) < 7);
      finish_pass(1'b1);
    end
    step(1'b0, 0, 1'b0);
    step(1'b0, 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
